// File: rtl/hazard_scoreboard_pkg.sv
// Shared encodings for the decode-stage hazard scoreboard: operand file
// selectors, FPU op codes of the iterative divider, and default divider latency.
package hazard_scoreboard_pkg;

    localparam int DIV_LATENCY_DEFAULT = 16;
    localparam int NUM_REGS            = 32;

    typedef enum logic [1:0] {
        RT_INT_INT = 2'b00,
        RT_INT_FP  = 2'b01,
        RT_FP_FP   = 2'b10,
        RT_FP3     = 2'b11
    } reg_type_e;

    localparam logic [4:0] FPU_FDIV  = 5'b00100;
    localparam logic [4:0] FPU_FSQRT = 5'b01101;

    // FDIV and FSQRT share the single iterative unit
    function automatic logic is_div_op(input logic [4:0] fpu_select);
        return (fpu_select == FPU_FDIV) || (fpu_select == FPU_FSQRT);
    endfunction

endpackage

// File: rtl/hazard_scoreboard_pending_vector.sv
// Per-register pending-write bit vector with one set port and one clear port;
// set beats clear on the same bit, and bit 0 can be pinned to zero for x0.
module pending_vector #(
    parameter int N       = 32,
    parameter bit MASK_X0 = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 set_en,
    input  logic [$clog2(N)-1:0] set_idx,
    input  logic                 clr_en,
    input  logic [$clog2(N)-1:0] clr_idx,
    output logic [N-1:0]         pending
);

    logic [N-1:0] set_mask;
    logic [N-1:0] clr_mask;
    logic [N-1:0] pending_next;

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (set_en) set_mask[set_idx] = 1'b1;
        if (clr_en) clr_mask[clr_idx] = 1'b1;
        pending_next = (pending & ~clr_mask) | set_mask;
        if (MASK_X0) pending_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) pending <= '0;
        else        pending <= pending_next;
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-stage RAW/WAW/structural hazard unit for the int and float files.
// Define HAZARD_WB_BYPASS_EN to let same-cycle writebacks resolve hazards.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int DIV_LATENCY = DIV_LATENCY_DEFAULT,
    parameter int XLEN_REGS   = NUM_REGS
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 DEC_VALID,
    input  logic [4:0]           DEC_RS1,
    input  logic [4:0]           DEC_RS2,
    input  logic [4:0]           DEC_RS3,
    input  logic                 DEC_RS1_USE,
    input  logic                 DEC_RS2_USE,
    input  logic [4:0]           DEC_RD,
    input  logic [1:0]           REG_TYPE,
    input  logic                 REG_WRITE_EN,
    input  logic                 FREG_WRITE_EN,
    input  logic [4:0]           FPU_SELECT,
    input  logic                 FLUSH,
    input  logic                 WB_INT_EN,
    input  logic [4:0]           WB_INT_RD,
    input  logic                 WB_FP_EN,
    input  logic [4:0]           WB_FP_RD,
    output logic                 STALL,
    output logic                 ISSUE,
    output logic                 DIV_BUSY,
    output logic [XLEN_REGS-1:0] INT_PENDING,
    output logic [XLEN_REGS-1:0] FP_PENDING
);

    localparam int CW = $clog2(DIV_LATENCY);

    logic [CW-1:0]        div_cnt;
    logic [XLEN_REGS-1:0] int_view;
    logic [XLEN_REGS-1:0] fp_view;
    logic                 rs1_fp, rs2_fp, fp3, use1, use2;
    logic                 raw, waw, structural, is_div;

`ifdef HAZARD_WB_BYPASS_EN
    logic [XLEN_REGS-1:0] int_wb_mask;
    logic [XLEN_REGS-1:0] fp_wb_mask;

    always_comb begin
        int_wb_mask = '0;
        fp_wb_mask  = '0;
        if (WB_INT_EN) int_wb_mask[WB_INT_RD] = 1'b1;
        if (WB_FP_EN)  fp_wb_mask[WB_FP_RD]   = 1'b1;
    end

    assign int_view = INT_PENDING & ~int_wb_mask;
    assign fp_view  = FP_PENDING  & ~fp_wb_mask;
`else
    assign int_view = INT_PENDING;
    assign fp_view  = FP_PENDING;
`endif

    // Operand file selection; the three-source form reads all of rs1..rs3 unconditionally
    always_comb begin
        fp3    = (REG_TYPE == RT_FP3);
        rs1_fp = REG_TYPE[1];
        rs2_fp = (REG_TYPE != RT_INT_INT);
        use1   = DEC_RS1_USE | fp3;
        use2   = DEC_RS2_USE | fp3;

        raw = 1'b0;
        if (use1) raw = raw | (rs1_fp ? fp_view[DEC_RS1] : ((DEC_RS1 != 5'd0) & int_view[DEC_RS1]));
        if (use2) raw = raw | (rs2_fp ? fp_view[DEC_RS2] : ((DEC_RS2 != 5'd0) & int_view[DEC_RS2]));
        if (fp3)  raw = raw | fp_view[DEC_RS3];

        waw = (REG_WRITE_EN & (DEC_RD != 5'd0) & int_view[DEC_RD])
            | (FREG_WRITE_EN & fp_view[DEC_RD]);

        is_div     = FREG_WRITE_EN & is_div_op(FPU_SELECT);
        structural = is_div & DIV_BUSY;
    end

    assign STALL    = RESET & DEC_VALID & (raw | waw | structural);
    assign ISSUE    = RESET & DEC_VALID & ~STALL & ~FLUSH;
    assign DIV_BUSY = (div_cnt != '0);

    always_ff @(posedge CLK) begin
        if (!RESET)               div_cnt <= '0;
        else if (ISSUE && is_div) div_cnt <= CW'(DIV_LATENCY - 1);
        else if (DIV_BUSY)        div_cnt <= div_cnt - 1'b1;
    end

    pending_vector #(.N(XLEN_REGS), .MASK_X0(1'b1)) u_int_pending (
        .clk     (CLK),
        .rst_n   (RESET),
        .set_en  (ISSUE & REG_WRITE_EN),
        .set_idx (DEC_RD),
        .clr_en  (WB_INT_EN),
        .clr_idx (WB_INT_RD),
        .pending (INT_PENDING)
    );

    pending_vector #(.N(XLEN_REGS), .MASK_X0(1'b0)) u_fp_pending (
        .clk     (CLK),
        .rst_n   (RESET),
        .set_en  (ISSUE & FREG_WRITE_EN),
        .set_idx (DEC_RD),
        .clr_en  (WB_FP_EN),
        .clr_idx (WB_FP_RD),
        .pending (FP_PENDING)
    );

endmodule
